// File: rtl/mcp_controller.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback plus the ALU function decoder.
module mcp_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    // state   | meaning
    // FETCH   | IR <= Mem[PC], PC <= PC+4
    // DECODE  | read regs, precompute branch target
    // MEMADR  | ALUOut <= A + SignImm
    // MEMRD   | read data memory at ALUOut
    // MEMWB   | rt <= Data
    // MEMWR   | Mem[ALUOut] <= B
    // RTYPEEX | ALUOut <= A op B
    // RTYPEWB | rd <= ALUOut
    // BEQEX   | compare A/B, take branch on zero
    // ADDIEX  | ALUOut <= A + SignImm
    // ADDIWB  | rt <= ALUOut
    // JEX     | PC <= jump target
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state_q;
    state_t     state_d;
    logic       pcwrite;
    logic       branch;
    logic       irwrite_s;
    logic       memwrite_s;
    logic       regwrite_s;
    logic [1:0] aluop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        case (state_q)
            FETCH: begin
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
                alusrcb   = 2'b01;
                state_d   = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYP:      state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: regwrite_s = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // Reset holds the state register at FETCH, so only the enables need masking.
    assign pcen     = reset_n & (pcwrite | (branch & zero));
    assign irwrite  = reset_n & irwrite_s;
    assign memwrite = reset_n & memwrite_s;
    assign regwrite = reset_n & regwrite_s;
    assign state    = state_q;

endmodule

// File: tb/tb_mcp_controller.sv
// Randomized scoreboard bench for mcp_controller: per-instruction expected
// cycle sequences are queued by the driver and popped by a per-cycle monitor.
module tb_mcp_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'b100011;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    mcp_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .iord(iord), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] v;
    } rec_t;

    rec_t q[$];
    rec_t mon_r;
    int   vectors = 0;
    int   miscompares = 0;

    logic [14:0] act_vec;
    assign act_vec = {pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg,
                      alusrca, alusrcb, pcsrc, alucontrol};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] alu_ref(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected control word for one step of an instruction, from the step table.
    function automatic logic [14:0] exp_vec(input int st, input logic [5:0] f, input logic z);
        logic pe, irw, mw, rw, io, rd, m2r, sa;
        logic [1:0] sb, ps;
        logic [2:0] alu;
        {pe, irw, mw, rw, io, rd, m2r, sa} = 8'b0;
        sb = 2'b00; ps = 2'b00; alu = 3'b010;
        case (st)
            0:  begin pe = 1; irw = 1; sb = 2'b01; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  io = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin sa = 1; alu = alu_ref(f); end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; alu = 3'b110; ps = 2'b01; pe = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        return {pe, irw, mw, rw, io, rd, m2r, sa, sb, ps, alu};
    endfunction

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        int steps[$];
        op = o; funct = f; zero = z;
        case (o)
            6'b100011: steps = '{0, 1, 2, 3, 4};
            6'b101011: steps = '{0, 1, 2, 5};
            6'b000000: steps = '{0, 1, 6, 7};
            6'b000100: steps = '{0, 1, 8};
            6'b001000: steps = '{0, 1, 9, 10};
            6'b000010: steps = '{0, 1, 11};
            default:   steps = '{0, 1};
        endcase
        foreach (steps[i]) q.push_back({4'(steps[i]), exp_vec(steps[i], f, z)});
        repeat (steps.size()) @(negedge clk);
    endtask

    always @(negedge clk) begin
        #2;
        if (q.size() > 0) begin
            mon_r = q.pop_front();
            check("state", 32'(state), 32'(mon_r.st));
            check("controls", 32'(act_vec), 32'(mon_r.v));
        end
        if (reset_n)
            check("wr_exclusive", 32'(32'(memwrite) + 32'(regwrite) + 32'(irwrite) <= 1), 32'd1);
    end

    logic [5:0] rfuncts [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    logic [5:0] ops     [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    initial begin
        repeat (3) begin
            @(negedge clk); #2;
            check("rst_state", 32'(state), 32'd0);
            check("rst_controls", 32'(act_vec), 32'(15'b0000_0000_01_00_010));
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_instr(6'b100011, 6'b0, 1'b0);
        run_instr(6'b101011, 6'b0, 1'b0);
        foreach (rfuncts[i]) run_instr(6'b000000, rfuncts[i], 1'b0);
        run_instr(6'b000100, 6'b0, 1'b1);
        run_instr(6'b000100, 6'b0, 1'b0);
        run_instr(6'b001000, 6'b0, 1'b1);
        run_instr(6'b000010, 6'b0, 1'b0);
        run_instr(6'b111111, 6'b0, 1'b1);

        // lw aborted by reset during MEMRD
        op = 6'b100011; funct = 6'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("midrst_pre_state", 32'(state), 32'd3);
        #2 reset_n = 1'b0;
        #1 check("midrst_state", 32'(state), 32'd0);
        check("midrst_regwrite", 32'(regwrite), 32'd0);
        repeat (2) begin
            @(negedge clk); #3;
            check("midrst_hold_state", 32'(state), 32'd0);
            check("midrst_hold_en", 32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        for (int n = 0; n < 300; n++) begin
            logic [5:0] o, f;
            int sel;
            sel = $urandom_range(0, 7);
            o = (sel < 6) ? ops[sel] : 6'($urandom);
            f = ($urandom_range(0, 1) == 1) ? rfuncts[$urandom_range(0, 5)] : 6'($urandom);
            run_instr(o, f, 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        #3 check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
